// File: rtl/brmask_mgr_pkg.sv
// Shared core definitions for branch-tag bookkeeping: tag count, the one-hot
// tag type and the per-cycle resolution classification.
package brmask_mgr_pkg;

    localparam int WIDTH_BRM = 4;

    typedef logic [WIDTH_BRM-1:0] brtag_t;

    typedef enum logic [1:0] {
        RES_NONE,
        RES_CORRECT,
        RES_MISPRED,
        RES_FLUSH
    } res_kind_e;

endpackage

// File: rtl/brmask_mgr_prio_enc_onehot.sv
// Lowest-index set-bit finder: returns the isolated lowest set bit of req_i
// as a one-hot vector, plus a flag saying whether any bit was set.
module prio_enc_onehot #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] req_i,
    output logic [WIDTH-1:0] onehot_o,
    output logic             vld_o
);

    // Two's-complement trick: x & -x keeps only the lowest set bit.
    assign onehot_o = req_i & (~req_i + WIDTH'(1));
    assign vld_o    = |req_i;

endmodule

// File: rtl/brmask_mgr.sv
// Branch-tag allocator: hands out one-hot tags at decode, tracks which tags
// each branch depends on, and produces kill masks on mispredict or flush.
module brmask_mgr #(
    parameter int WIDTH_BRM = brmask_mgr_pkg::WIDTH_BRM
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_alloc_req,
    output logic                 o_alloc_gnt,
    output logic [WIDTH_BRM-1:0] o_alloc_tag,
    output logic [WIDTH_BRM-1:0] o_brmask,
    input  logic                 i_res_vld,
    input  logic [WIDTH_BRM-1:0] i_res_tag,
    input  logic                 i_res_mispred,
    input  logic                 i_flush,
    output logic                 o_kill_vld,
    output logic [WIDTH_BRM-1:0] o_kill_mask,
    output logic                 o_full
);
    import brmask_mgr_pkg::*;

    logic [WIDTH_BRM-1:0] live_q, live_d;
    logic [WIDTH_BRM-1:0] dep_q [WIDTH_BRM];
    logic [WIDTH_BRM-1:0] dep_d [WIDTH_BRM];
    logic                 kill_vld_q, kill_vld_d;
    logic [WIDTH_BRM-1:0] kill_mask_q, kill_mask_d;
    logic                 full_q, full_d;

    res_kind_e            res_kind;
    logic                 res_ok;
    logic [WIDTH_BRM-1:0] res_clr;
    logic [WIDTH_BRM-1:0] kill_set;
    logic [WIDTH_BRM-1:0] free_onehot;
    logic                 free_vld;
    logic                 gnt;

    // Free tags come from the registered live mask, so a tag freed this cycle
    // only becomes grantable after the edge.
    prio_enc_onehot #(
        .WIDTH (WIDTH_BRM)
    ) u_free_enc (
        .req_i    (~live_q),
        .onehot_o (free_onehot),
        .vld_o    (free_vld)
    );

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        res_ok   = i_res_vld && $onehot(i_res_tag) && ((i_res_tag & live_q) != '0);
        res_kind = RES_NONE;
        if (i_flush) begin
            res_kind = RES_FLUSH;
        end else if (res_ok && i_res_mispred) begin
            res_kind = RES_MISPRED;
        end else if (res_ok) begin
            res_kind = RES_CORRECT;
        end
        res_clr = (res_kind == RES_CORRECT) ? i_res_tag : '0;
    end

    // Stale dep entries of dead tags may still name r, so the result is
    // clipped to the live set.
    always_comb begin
        kill_set = i_res_tag;
        for (int j = 0; j < WIDTH_BRM; j++) begin
            if ((dep_q[j] & i_res_tag) != '0) begin
                kill_set[j] = 1'b1;
            end
        end
        kill_set = kill_set & live_q;
    end

    assign gnt         = i_alloc_req && free_vld && !i_flush && !(i_res_vld && i_res_mispred);
    assign o_alloc_gnt = gnt;
    assign o_alloc_tag = free_onehot;

    always_comb begin
        live_d      = live_q;
        dep_d       = dep_q;
        kill_vld_d  = 1'b0;
        kill_mask_d = '0;
        case (res_kind)
            RES_FLUSH: begin
                live_d      = '0;
                for (int j = 0; j < WIDTH_BRM; j++) dep_d[j] = '0;
                kill_vld_d  = 1'b1;
                kill_mask_d = '1;
            end
            RES_MISPRED: begin
                live_d      = live_q & ~kill_set;
                kill_vld_d  = 1'b1;
                kill_mask_d = kill_set;
            end
            RES_CORRECT: begin
                live_d = live_q & ~i_res_tag;
                for (int j = 0; j < WIDTH_BRM; j++) dep_d[j] = dep_q[j] & ~i_res_tag;
            end
            default: ;
        endcase
        if (gnt) begin
            live_d = live_d | free_onehot;
            for (int j = 0; j < WIDTH_BRM; j++) begin
                if (free_onehot[j]) dep_d[j] = live_q & ~res_clr;
            end
        end
        full_d = &live_d;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            live_q      <= '0;
            // NOTE: the dep array is reset too; a flush-free path could otherwise kill from X entries.
            for (int j = 0; j < WIDTH_BRM; j++) dep_q[j] <= '0;
            kill_vld_q  <= 1'b0;
            kill_mask_q <= '0;
            full_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so all state updates see pre-edge values.
            live_q      <= live_d;
            dep_q       <= dep_d;
            kill_vld_q  <= kill_vld_d;
            kill_mask_q <= kill_mask_d;
            full_q      <= full_d;
        end
    end

    assign o_brmask    = live_q;
    assign o_kill_vld  = kill_vld_q;
    assign o_kill_mask = kill_mask_q;
    assign o_full      = full_q;

endmodule

// File: tb/tb_brmask_mgr.sv
// Scoreboard bench for brmask_mgr: stimulus queues expected grants and kills,
// a negedge monitor pops and compares whenever the DUT presents them.
module tb_brmask_mgr;
    import brmask_mgr_pkg::*;

    localparam int W = 4;

    typedef struct {
        logic         gnt;
        logic [W-1:0] tag;
    } gnt_exp_t;

    logic         clk;
    logic         rst_n;
    logic         i_alloc_req;
    logic         o_alloc_gnt;
    logic [W-1:0] o_alloc_tag;
    logic [W-1:0] o_brmask;
    logic         i_res_vld;
    logic [W-1:0] i_res_tag;
    logic         i_res_mispred;
    logic         i_flush;
    logic         o_kill_vld;
    logic [W-1:0] o_kill_mask;
    logic         o_full;

    gnt_exp_t     gnt_q[$];
    brtag_t       kill_q[$];
    int           n_checks = 0;
    int           n_fail   = 0;

    brmask_mgr #(.WIDTH_BRM(W)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_alloc_req   (i_alloc_req),
        .o_alloc_gnt   (o_alloc_gnt),
        .o_alloc_tag   (o_alloc_tag),
        .o_brmask      (o_brmask),
        .i_res_vld     (i_res_vld),
        .i_res_tag     (i_res_tag),
        .i_res_mispred (i_res_mispred),
        .i_flush       (i_flush),
        .o_kill_vld    (o_kill_vld),
        .o_kill_mask   (o_kill_mask),
        .o_full        (o_full)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: DUT output with no expected entry queued", name);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic alloc(input logic [W-1:0] tag);
        i_alloc_req = 1'b1;
        gnt_q.push_back('{1'b1, tag});
        step();
        i_alloc_req = 1'b0;
    endtask

    // One-cycle resolution; optionally with a simultaneous request / flush.
    task automatic resolve(input logic [W-1:0] tag, input logic mis, input logic flush,
                           input logic req, input gnt_exp_t g,
                           input logic kill_exp, input logic [W-1:0] kmask);
        i_res_vld     = 1'b1;
        i_res_tag     = tag;
        i_res_mispred = mis;
        i_flush       = flush;
        i_alloc_req   = req;
        if (req) gnt_q.push_back(g);
        if (kill_exp) kill_q.push_back(kmask);
        step();
        i_res_vld     = 1'b0;
        i_res_tag     = '0;
        i_res_mispred = 1'b0;
        i_flush       = 1'b0;
        i_alloc_req   = 1'b0;
    endtask

    // Monitor: grants are compared in the cycle they are requested, kills in
    // the cycle the DUT raises o_kill_vld.
    initial begin
        gnt_exp_t g;
        brtag_t   k;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (i_alloc_req) begin
                    if (gnt_q.size() == 0) unexpected("alloc");
                    else begin
                        g = gnt_q.pop_front();
                        check("alloc_gnt", 32'(o_alloc_gnt), 32'(g.gnt));
                        if (g.gnt) check("alloc_tag", 32'(o_alloc_tag), 32'(g.tag));
                    end
                end
                if (o_kill_vld) begin
                    if (kill_q.size() == 0) unexpected("kill_vld");
                    else begin
                        k = kill_q.pop_front();
                        check("kill_mask", 32'(o_kill_mask), 32'(k));
                    end
                end
            end
        end
    end

    initial begin
        gnt_exp_t none = '{1'b0, '0};
        rst_n         = 1'b0;
        i_alloc_req   = 1'b0;
        i_res_vld     = 1'b0;
        i_res_tag     = '0;
        i_res_mispred = 1'b0;
        i_flush       = 1'b0;
        #2;
        check("reset_brmask", 32'(o_brmask), 32'h0);
        check("reset_full", 32'(o_full), 32'h0);
        check("reset_kill_vld", 32'(o_kill_vld), 32'h0);
        check("reset_kill_mask", 32'(o_kill_mask), 32'h0);
        step();
        rst_n = 1'b1;
        step();

        // Four back-to-back grants fill the tag space; fifth is refused.
        alloc(4'b0001);
        alloc(4'b0010);
        alloc(4'b0100);
        check("fill_full_early", 32'(o_full), 32'h0);
        alloc(4'b1000);
        check("fill_full", 32'(o_full), 32'h1);
        check("fill_brmask", 32'(o_brmask), 32'hF);
        i_alloc_req = 1'b1;
        gnt_q.push_back(none);
        step();
        i_alloc_req = 1'b0;
        check("full_brmask_hold", 32'(o_brmask), 32'hF);

        // Flush with a simultaneous correct resolution: flush wins.
        resolve(4'b0010, 1'b0, 1'b1, 1'b0, none, 1'b1, 4'b1111);
        check("flush_brmask", 32'(o_brmask), 32'h0);
        check("flush_full", 32'(o_full), 32'h0);
        step();

        // Mispredict of tag 1 with tags 0-3 live kills 1,2,3.
        alloc(4'b0001);
        alloc(4'b0010);
        alloc(4'b0100);
        alloc(4'b1000);
        resolve(4'b0010, 1'b1, 1'b0, 1'b0, none, 1'b1, 4'b1110);
        check("mis1_brmask", 32'(o_brmask), 32'h1);
        check("mis1_full", 32'(o_full), 32'h0);
        step();
        step();
        resolve(4'b0001, 1'b0, 1'b0, 1'b0, none, 1'b0, '0);
        check("drain_brmask", 32'(o_brmask), 32'h0);

        // Correct resolve of tag 0, then mispredict of tag 1 kills 1,2.
        alloc(4'b0001);
        alloc(4'b0010);
        alloc(4'b0100);
        resolve(4'b0001, 1'b0, 1'b0, 1'b0, none, 1'b0, '0);
        check("ok0_brmask", 32'(o_brmask), 32'h6);
        step();
        resolve(4'b0010, 1'b1, 1'b0, 1'b0, none, 1'b1, 4'b0110);
        check("mis_after_ok_brmask", 32'(o_brmask), 32'h0);
        step();

        // Request with a same-cycle correct resolve: freed tag 0 is not reused.
        alloc(4'b0001);
        alloc(4'b0010);
        resolve(4'b0001, 1'b0, 1'b0, 1'b1, '{1'b1, 4'b0100}, 1'b0, '0);
        check("same_cyc_brmask", 32'(o_brmask), 32'h6);
        alloc(4'b0001);
        // dep[2] must be 0010: mispredicting new tag 0 kills only tag 0.
        resolve(4'b0001, 1'b1, 1'b0, 1'b0, none, 1'b1, 4'b0001);
        check("dep2_no_bit0_brmask", 32'(o_brmask), 32'h6);
        resolve(4'b0010, 1'b1, 1'b0, 1'b0, none, 1'b1, 4'b0110);
        check("dep2_bit1_brmask", 32'(o_brmask), 32'h0);
        step();

        // Request during a mispredict is refused.
        alloc(4'b0001);
        resolve(4'b0001, 1'b1, 1'b0, 1'b1, none, 1'b1, 4'b0001);
        check("req_mis_brmask", 32'(o_brmask), 32'h0);
        step();

        // Resolutions of non-live or non-one-hot tags are ignored.
        resolve(4'b0100, 1'b1, 1'b0, 1'b0, none, 1'b0, '0);
        check("ign_nonlive_brmask", 32'(o_brmask), 32'h0);
        alloc(4'b0001);
        alloc(4'b0010);
        resolve(4'b0011, 1'b1, 1'b0, 1'b0, none, 1'b0, '0);
        check("ign_multihot_brmask", 32'(o_brmask), 32'h3);
        resolve(4'b0100, 1'b0, 1'b0, 1'b0, none, 1'b0, '0);
        check("ign_ok_nonlive_brmask", 32'(o_brmask), 32'h3);

        // Flush together with a mispredict: full kill mask.
        resolve(4'b0001, 1'b1, 1'b1, 1'b0, none, 1'b1, 4'b1111);
        check("flush_mis_brmask", 32'(o_brmask), 32'h0);
        step();

        // Reset lands while a kill strobe is showing: both clear at once.
        alloc(4'b0001);
        alloc(4'b0010);
        resolve(4'b0001, 1'b1, 1'b0, 1'b0, none, 1'b0, '0);
        rst_n = 1'b0;
        #1;
        check("rst_mid_kill_vld", 32'(o_kill_vld), 32'h0);
        check("rst_mid_brmask", 32'(o_brmask), 32'h0);
        check("rst_mid_kill_mask", 32'(o_kill_mask), 32'h0);
        step();
        rst_n = 1'b1;
        step();
        check("post_rst_kill_vld", 32'(o_kill_vld), 32'h0);
        alloc(4'b0001);
        check("post_rst_brmask", 32'(o_brmask), 32'h1);

        step();
        step();
        check("gnt_queue_drained", 32'(gnt_q.size()), 32'h0);
        check("kill_queue_drained", 32'(kill_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
